if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage of the 16-bit pipeline. It is the producer end of the IF/ID interface whose consumer is the decode stage.
- Owns the PC and drives a single-outstanding request/ack port into instruction memory. Registers {pc, inst} into the IF/ID latch that feeds decode's pc_i/inst_i.
- Consumes decode's branch_flag/branch_addr with one architectural delay slot. Also takes pipeline stall and flush from control.

Parameters:
RESET_PC, 16'h0000, word address fetched first after reset
NOP_INST, 16'h0800, encoding loaded into IF/ID on reset, bubble or flush

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_i  in  1  hold IF/ID latch (decode not accepting)
flush_i  in  1  discard IF/ID contents and redirect fetch
flush_addr_i  in  16  redirect target for flush_i
branch_flag_i  in  1  decode resolved a taken branch/jump
branch_addr_i  in  16  branch target word address
imem_req_o  out  1  fetch request, held until ack
imem_addr_o  out  16  fetch word address, stable while req high
imem_ack_i  in  1  rdata valid this cycle; may coincide with first req cycle
imem_rdata_i  in  16  fetched instruction
id_pc_o  out  16  IF/ID latched PC
id_inst_o  out  16  IF/ID latched instruction
id_valid_o  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, addr_q=RESET_PC, state=FETCH, redir_v=0.
  - id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0.
  - imem_req_o forced 0 while rst=0.
  - Reset mid-transaction abandons it; memory must tolerate a dropped req.
- Address rules: word addressing. Sequential next address = pc+1, wrapping 16'hFFFF -> 16'h0000.
- Next-PC select, in priority order: branch_flag_i ? branch_addr_i : redir_v ? redir_q : pc+1.
- imem_req_o = (state==FETCH || state==DRAIN). imem_addr_o = addr_q. addr_q loads the new pc at the same edge pc updates, so the address is stable for a whole request.
- State FETCH:
  - ack=1, stall_i=0, flush_i=0: IF/ID <= {addr_q, rdata, valid=1}. pc, addr_q <= next-PC. redir_v <= 0. Stay FETCH, so back-to-back fetches give 1 instr/cycle with a zero-wait memory.
  - ack=1, stall_i=1: capture rdata in hold buffer; IF/ID unchanged; go HOLD.
  - ack=0, stall_i=0: IF/ID <= bubble {0, NOP_INST, 0}.
  - ack=0, stall_i=1: IF/ID unchanged.
- State HOLD:
  - req=0.
  - When stall_i=0: IF/ID <= {addr_q, hold buffer, 1}; pc, addr_q <= next-PC; redir_v <= 0; go FETCH.
- State DRAIN (flush during an outstanding request):
  - req stays high on the old addr_q.
  - On ack: discard data; addr_q <= pc (the flush target); go FETCH.
- Branch / delay slot:
  - The instruction being fetched or held when branch_flag_i is seen is the delay slot and is delivered normally.
  - branch_flag_i=1 in any cycle without a delivery: redir_q <= branch_addr_i, redir_v <= 1.
  - Delivery in the same cycle as branch_flag_i: branch_addr_i is used directly.
  - Bubbles never consume redir_v.
- Flush (highest priority after reset):
  - IF/ID <= bubble; pc <= flush_addr_i; redir_v <= 0.
  - From FETCH with ack=1, or from HOLD: addr_q <= flush_addr_i; state FETCH.
  - From FETCH with ack=0: go DRAIN.
  - Flush while already in DRAIN: update pc only.
  - flush_i overrides stall_i and branch_flag_i.
- Latency: zero-wait memory gives instruction at IF/ID one cycle after its request cycle.

Test Plan:
- Reset release, ack tied 1: fetch addresses 0,1,2,3. IF/ID shows (0,rdata0),(1,rdata1)… on consecutive cycles, id_valid_o=1 from the second cycle.
- Ack delayed 2 cycles at addr 5: imem_addr_o holds 5 for 3 cycles, two bubbles (NOP 16'h0800, valid=0) enter IF/ID, then (5,inst). Next fetch is 6.
- stall_i high 3 cycles while ack returns addr 8: IF/ID holds its previous value, req drops. On release IF/ID=(8,inst) and the next request is 9.
- Branch at 0x10, branch_flag_i=1 with target 0x40 while 0x11 is fetching (ack=0, then ack): 0x11 delivered as the delay slot, next request 0x40. Repeat with ack in the branch cycle and check the same result.
- flush_i with flush_addr_i=0x0100 while addr 0x22 is unacked: req stays on 0x22 until ack, data discarded, IF/ID bubble, next request 0x0100.
- Wrap: pc=16'hFFFF acked -> next request 16'h0000. Async reset asserted mid-wait: req drops immediately, IF/ID=NOP; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests
// and loads the IF/ID latch, honouring stall, flush and a one-slot branch delay.
module if_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [15:0] flush_addr_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [15:0] imem_rdata_i,
   output logic [15:0] id_pc_o,
   output logic [15:0] id_inst_o,
   output logic        id_valid_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_HOLD  = 2'b01,
      S_DRAIN = 2'b10
   } state_t;

   state_t      state_r;
   logic [15:0] pc_r;
   logic [15:0] addr_r;
   logic [15:0] redir_r;
   logic        redir_v_r;
   logic [15:0] hold_r;
   logic [15:0] id_pc_r;
   logic [15:0] id_inst_r;
   logic        id_valid_r;
   logic [15:0] next_pc_s;

   // Next fetch address: a branch resolved this cycle beats a pending redirect.
   always_comb begin
      next_pc_s = pc_r + 16'd1;
      if (branch_flag_i) begin
         next_pc_s = branch_addr_i;
      end else if (redir_v_r) begin
         next_pc_s = redir_r;
      end else begin
         next_pc_s = pc_r + 16'd1;
      end
   end

   // Fetch sequencing, PC/address update and IF/ID latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_FETCH;
         pc_r       <= RESET_PC;
         addr_r     <= RESET_PC;
         redir_r    <= 16'h0000;
         redir_v_r  <= 1'b0;
         hold_r     <= 16'h0000;
         id_pc_r    <= 16'h0000;
         id_inst_r  <= NOP_INST;
         id_valid_r <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (flush_i) begin
                  id_pc_r    <= 16'h0000;
                  id_inst_r  <= NOP_INST;
                  id_valid_r <= 1'b0;
                  pc_r       <= flush_addr_i;
                  redir_v_r  <= 1'b0;
                  if (imem_ack_i) begin
                     addr_r <= flush_addr_i;
                  end else begin
                     state_r <= S_DRAIN;
                  end
               end else if (imem_ack_i && !stall_i) begin
                  id_pc_r    <= addr_r;
                  id_inst_r  <= imem_rdata_i;
                  id_valid_r <= 1'b1;
                  pc_r       <= next_pc_s;
                  addr_r     <= next_pc_s;
                  redir_v_r  <= 1'b0;
               end else begin
                  if (imem_ack_i) begin
                     hold_r  <= imem_rdata_i;
                     state_r <= S_HOLD;
                  end else if (!stall_i) begin
                     id_pc_r    <= 16'h0000;
                     id_inst_r  <= NOP_INST;
                     id_valid_r <= 1'b0;
                  end
                  if (branch_flag_i) begin
                     redir_r   <= branch_addr_i;
                     redir_v_r <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (flush_i) begin
                  id_pc_r    <= 16'h0000;
                  id_inst_r  <= NOP_INST;
                  id_valid_r <= 1'b0;
                  pc_r       <= flush_addr_i;
                  addr_r     <= flush_addr_i;
                  redir_v_r  <= 1'b0;
                  state_r    <= S_FETCH;
               end else if (!stall_i) begin
                  id_pc_r    <= addr_r;
                  id_inst_r  <= hold_r;
                  id_valid_r <= 1'b1;
                  pc_r       <= next_pc_s;
                  addr_r     <= next_pc_s;
                  redir_v_r  <= 1'b0;
                  state_r    <= S_FETCH;
               end else if (branch_flag_i) begin
                  redir_r   <= branch_addr_i;
                  redir_v_r <= 1'b1;
               end
            end
            // The old request must complete before the flush target is issued.
            S_DRAIN: begin
               if (flush_i) begin
                  id_pc_r    <= 16'h0000;
                  id_inst_r  <= NOP_INST;
                  id_valid_r <= 1'b0;
                  pc_r       <= flush_addr_i;
                  redir_v_r  <= 1'b0;
                  if (imem_ack_i) begin
                     addr_r  <= flush_addr_i;
                     state_r <= S_FETCH;
                  end
               end else if (imem_ack_i) begin
                  addr_r  <= pc_r;
                  state_r <= S_FETCH;
               end else if (branch_flag_i) begin
                  redir_r   <= branch_addr_i;
                  redir_v_r <= 1'b1;
               end
            end
            default: begin
               state_r    <= S_FETCH;
               id_pc_r    <= 16'h0000;
               id_inst_r  <= NOP_INST;
               id_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_o  = rst & ((state_r == S_FETCH) | (state_r == S_DRAIN));
   assign imem_addr_o = addr_r;
   assign id_pc_o     = id_pc_r;
   assign id_inst_o   = id_inst_r;
   assign id_valid_o  = id_valid_r;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected IF/ID contents are queued as each
// cycle's stimulus is driven and compared just after the clock edge.
module tb_if_fetch;

   localparam logic [15:0] NOP = 16'h0800;
   localparam int K_KEEP = 0;
   localparam int K_BUB  = 1;
   localparam int K_DEL  = 2;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] inst;
      logic        valid;
   } ifid_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [15:0] flush_addr_i;
   logic        branch_flag_i;
   logic [15:0] branch_addr_i;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_ack_i;
   logic [15:0] imem_rdata_i;
   logic [15:0] id_pc_o;
   logic [15:0] id_inst_o;
   logic        id_valid_o;

   ifid_t sb_q[$];
   ifid_t exp_r;
   ifid_t mon_e;
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(16'h0000), .NOP_INST(16'h0800)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .flush_addr_i (flush_addr_i),
      .branch_flag_i(branch_flag_i),
      .branch_addr_i(branch_addr_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rdata_i (imem_rdata_i),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o),
      .id_valid_o   (id_valid_o)
   );

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a ^ 16'hC35A;
   endfunction

   // Memory model returns garbage whenever no request is outstanding.
   assign imem_rdata_i = imem_req_o ? mem_f(imem_addr_o) : 16'hDEAD;

   task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check_val("id_pc", id_pc_o, mon_e.pc);
         check_val("id_inst", id_inst_o, mon_e.inst);
         check_val("id_valid", {15'd0, id_valid_o}, {15'd0, mon_e.valid});
      end
   end

   task automatic step(input logic st, input logic fl, input logic [15:0] fa,
                       input logic bf, input logic [15:0] ba, input logic ak,
                       input logic er, input logic [15:0] ea, input int kind,
                       input logic [15:0] da);
      stall_i       = st;
      flush_i       = fl;
      flush_addr_i  = fa;
      branch_flag_i = bf;
      branch_addr_i = ba;
      imem_ack_i    = ak;
      #1;
      check_val("req", {15'd0, imem_req_o}, {15'd0, er});
      check_val("addr", imem_addr_o, ea);
      case (kind)
         K_BUB:   exp_r = {16'h0000, NOP, 1'b0};
         K_DEL:   exp_r = {da, mem_f(da), 1'b1};
         default: exp_r = exp_r;
      endcase
      sb_q.push_back(exp_r);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic ak, input logic [15:0] ea, input int kind, input logic [15:0] da);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, ak, 1'b1, ea, kind, da);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_req"}, {15'd0, imem_req_o}, 16'h0000);
      check_val({tag, "_pc"}, id_pc_o, 16'h0000);
      check_val({tag, "_inst"}, id_inst_o, NOP);
      check_val({tag, "_valid"}, {15'd0, id_valid_o}, 16'h0000);
   endtask

   initial begin
      rst = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0; flush_addr_i = 16'h0000;
      branch_flag_i = 1'b0; branch_addr_i = 16'h0000; imem_ack_i = 1'b0;
      exp_r = {16'h0000, NOP, 1'b0};
      @(posedge clk); @(posedge clk); #2;
      check_reset_state("rst");
      rst = 1'b1;

      // Zero-wait back-to-back fetch from RESET_PC.
      for (int i = 0; i < 5; i++) run(1'b1, 16'(i), K_DEL, 16'(i));
      // Ack delayed two cycles at address 5.
      run(1'b0, 16'h0005, K_BUB, 16'h0000);
      run(1'b0, 16'h0005, K_BUB, 16'h0000);
      run(1'b1, 16'h0005, K_DEL, 16'h0005);
      run(1'b1, 16'h0006, K_DEL, 16'h0006);
      run(1'b1, 16'h0007, K_DEL, 16'h0007);
      // Stall for three cycles while address 8 is acked.
      step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, K_KEEP, 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, K_KEEP, 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, K_KEEP, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, K_DEL, 16'h0008);
      for (int i = 9; i <= 16; i++) run(1'b1, 16'(i), K_DEL, 16'(i));
      // Branch to 0x40 while 0x11 is unacked; an extra bubble must not consume the redirect.
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0011, K_BUB, 16'h0000);
      run(1'b0, 16'h0011, K_BUB, 16'h0000);
      run(1'b1, 16'h0011, K_DEL, 16'h0011);
      run(1'b1, 16'h0040, K_DEL, 16'h0040);
      // Branch coinciding with the delay-slot ack.
      run(1'b1, 16'h0041, K_DEL, 16'h0041);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0042, K_DEL, 16'h0042);
      run(1'b1, 16'h0040, K_DEL, 16'h0040);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0022, 1'b1, 1'b1, 16'h0041, K_DEL, 16'h0041);
      // Flush (with stall and branch also raised) while 0x22 is outstanding.
      step(1'b1, 1'b1, 16'h0100, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h0022, K_BUB, 16'h0000);
      run(1'b0, 16'h0022, K_BUB, 16'h0000);
      run(1'b1, 16'h0022, K_BUB, 16'h0000);
      run(1'b1, 16'h0100, K_DEL, 16'h0100);
      // Flush with ack to 0xFFFF, then sequential wrap to 0x0000.
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101, K_BUB, 16'h0000);
      run(1'b1, 16'hFFFF, K_DEL, 16'hFFFF);
      run(1'b1, 16'h0000, K_DEL, 16'h0000);
      // Asynchronous reset in the middle of a waiting request.
      imem_ack_i = 1'b0;
      #1;
      check_val("pre_rst_req", {15'd0, imem_req_o}, 16'h0001);
      rst = 1'b0;
      #1;
      check_reset_state("async_rst");
      @(posedge clk); #2;
      check_reset_state("held_rst");
      rst = 1'b1;
      exp_r = {16'h0000, NOP, 1'b0};
      run(1'b1, 16'h0000, K_DEL, 16'h0000);
      run(1'b1, 16'h0001, K_DEL, 16'h0001);

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
